seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu.sv | 174 +++++++++++++++++
 tb/tb_seq_alu.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu_if : request/result bundle between a seq_alu and its user   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, carry, illegal
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, carry, illegal
  );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu : single-cycle ALU ops plus optional shift-add multiplier   |
// | Multiplier built only when SEQ_ALU_MUL_EN is defined. Rev 1.0      |
// +--------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 8
) (
  input wire       clk,
  input wire       rst,
  seq_alu_if.slave bus_io
);
  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_not = 3'b010;
  localparam logic [2:0] c_op_and = 3'b011;
  localparam logic [2:0] c_op_or  = 3'b100;
  localparam logic [2:0] c_op_xor = 3'b101;
  localparam logic [2:0] c_op_shl = 3'b110;
  localparam logic [2:0] c_op_mul = 3'b111;

`ifdef SEQ_ALU_MUL_EN
  localparam logic c_mul_en = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIN = 2'd2} state_t;
`else
  localparam logic c_mul_en = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, FIN = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             illegal_q, illegal_d;

  logic             w_busy;
  logic             w_start_mul;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_illegal;

`ifdef SEQ_ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] w_acc_sum;

  assign w_busy    = (state_q == MUL);
  assign w_acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign w_busy    = 1'b0;
`endif

  assign w_start_mul = c_mul_en && (bus_io.op == c_op_mul);

  always_comb begin : p_alu
    w_ext         = '0;
    w_alu_res     = '0;
    w_alu_carry   = 1'b0;
    w_alu_illegal = 1'b0;
    case (bus_io.op)
      c_op_add: begin
        w_ext       = {1'b0, bus_io.a} + {1'b0, bus_io.b};
        w_alu_res   = w_ext[WIDTH-1:0];
        w_alu_carry = w_ext[WIDTH];
      end
      c_op_sub: begin
        // top bit of the extended difference is the unsigned borrow
        w_ext       = {1'b0, bus_io.a} - {1'b0, bus_io.b};
        w_alu_res   = w_ext[WIDTH-1:0];
        w_alu_carry = w_ext[WIDTH];
      end
      c_op_not: w_alu_res = ~bus_io.a;
      c_op_and: w_alu_res = bus_io.a & bus_io.b;
      c_op_or:  w_alu_res = bus_io.a | bus_io.b;
      c_op_xor: w_alu_res = bus_io.a ^ bus_io.b;
      c_op_shl: begin
        w_alu_res   = {bus_io.a[WIDTH-2:0], 1'b0};
        w_alu_carry = bus_io.a[WIDTH-1];
      end
      default:  w_alu_illegal = ~c_mul_en;
    endcase
  end

  always_comb begin : p_next
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = illegal_q;
`ifdef SEQ_ALU_MUL_EN
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
`ifdef SEQ_ALU_MUL_EN
      MUL: begin
        acc_d    = w_acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d   = FIN;
          result_d  = w_acc_sum[WIDTH-1:0];
          carry_d   = |w_acc_sum[2*WIDTH-1:WIDTH];
          zero_d    = (w_acc_sum[WIDTH-1:0] == '0);
          illegal_d = 1'b0;
        end
      end
`endif
      default: begin
        // IDLE and FIN both accept; unused encodings fall back to IDLE
        state_d = IDLE;
        if (bus_io.start && !w_start_mul) begin
          state_d   = FIN;
          result_d  = w_alu_res;
          carry_d   = w_alu_carry;
          zero_d    = (w_alu_res == '0);
          illegal_d = w_alu_illegal;
        end
`ifdef SEQ_ALU_MUL_EN
        if (bus_io.start && w_start_mul) begin
          state_d  = MUL;
          mcand_d  = {{WIDTH{1'b0}}, bus_io.a};
          mplier_d = bus_io.b;
          acc_d    = '0;
          cnt_d    = '0;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
`ifdef SEQ_ALU_MUL_EN
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus_io.busy    = w_busy;
  assign bus_io.done    = (state_q == FIN);
  assign bus_io.result  = result_q;
  assign bus_io.zero    = zero_q;
  assign bus_io.carry   = carry_q;
  assign bus_io.illegal = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_alu : directed vectors with a transaction-level ALU model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_seq_alu;
  localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: each op's result from plain arithmetic on the operands.
  function automatic void calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [W-1:0] r, output logic c, output logic il);
    int s;
    r = '0; c = 1'b0; il = 1'b0; s = 0;
    case (o)
      3'd0: begin s = int'(x) + int'(y); r = W'(s); c = (s >= (1 << W)); end
      3'd1: begin r = x - y; c = (x < y); end
      3'd2: r = ~x;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: begin s = int'(x) * 2; r = W'(s); c = (s >= (1 << W)); end
      default: begin
        if (MUL_EN) begin s = int'(x) * int'(y); r = W'(s); c = (s >= (1 << W)); end
        else il = 1'b1;
      end
    endcase
  endfunction

  logic [W-1:0] m_res, p_res;
  logic         m_zero, m_carry, m_ill, m_done, p_carry;
  int           m_left;

  always @(posedge clk) begin
    logic [W-1:0] r;
    logic         c, il;
    if (rst) begin
      m_res = '0; m_zero = 0; m_carry = 0; m_ill = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_res = p_res; m_carry = p_carry; m_ill = 1'b0; m_zero = (p_res == '0); m_done = 1'b1;
        end
      end else if (bus.start) begin
        calc(bus.op, bus.a, bus.b, r, c, il);
        if (bus.op == 3'b111 && MUL_EN) begin
          m_left = W; p_res = r; p_carry = c;
        end else begin
          m_res = r; m_carry = c; m_ill = il; m_zero = (r == '0); m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done",    bus.done,    m_done);
      chk("busy",    bus.busy,    m_left > 0);
      chk("result",  bus.result,  m_res);
      chk("zero",    bus.zero,    m_zero);
      chk("carry",   bus.carry,   m_carry);
      chk("illegal", bus.illegal, m_ill);
    end
  end

  // Called on a falling edge; returns one falling edge after the request edge.
  task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 3'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
  endtask

  task automatic chk_out(input string nm, input logic [W-1:0] r, input logic z, input logic c,
                         input logic il, input logic d);
    chk({nm, "_result"},  bus.result,  r);
    chk({nm, "_zero"},    bus.zero,    z);
    chk({nm, "_carry"},   bus.carry,   c);
    chk({nm, "_illegal"}, bus.illegal, il);
    chk({nm, "_done"},    bus.done,    d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n_busy;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("reset", 8'h00, 0, 0, 0, 0);
    chk("reset_busy", bus.busy, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    drive(3'd0, 8'hF0, 8'h20);
    chk_out("add", 8'h10, 0, 1, 0, 1);
    @(negedge clk);
    chk("add_done_pulse", bus.done, 0);
    chk("add_hold", bus.result, 8'h10);

    drive(3'd1, 8'h05, 8'h05);
    chk_out("sub_eq", 8'h00, 1, 0, 0, 1);
    drive(3'd1, 8'h03, 8'h05);
    chk_out("sub_borrow", 8'hFE, 0, 1, 0, 1);

    drive(3'd2, 8'h5A, 8'h00);
    chk_out("not", 8'hA5, 0, 0, 0, 1);
    drive(3'd4, 8'h0F, 8'h30);
    drive(3'd5, 8'hFF, 8'hFF);
    chk_out("xor_zero", 8'h00, 1, 0, 0, 1);
    drive(3'd6, 8'h40, 8'h00);
    chk_out("shl_nc", 8'h80, 0, 0, 0, 1);
    repeat (2) @(negedge clk);

    // back-to-back with start held high
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 8'hCC; bus.b = 8'hAA;
    @(negedge clk);
    chk_out("b2b_and", 8'h88, 0, 0, 0, 1);
    bus.op = 3'd6; bus.a = 8'h81; bus.b = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    chk_out("b2b_shl", 8'h02, 0, 1, 0, 1);
    @(negedge clk);
    chk("b2b_end_done", bus.done, 0);

    if (MUL_EN) begin
      drive(3'd7, 8'h10, 8'h11);
      n = 0; n_busy = 0;
      while (!bus.done && n < 20) begin
        if (bus.busy) n_busy++;
        bus.start = (n == 2);
        bus.op = 3'd0; bus.a = 8'h01; bus.b = 8'h01;
        n++;
        @(negedge clk);
      end
      bus.start = 1'b0;
      chk("mul_latency", n, 8);
      chk("mul_busy_cycles", n_busy, 8);
      chk_out("mul", 8'h10, 0, 1, 0, 1);
      @(negedge clk);

      drive(3'd7, 8'hFF, 8'hFF);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_out("mul_rst", 8'h00, 0, 0, 0, 0);
      chk("mul_rst_busy", bus.busy, 0);
      repeat (10) @(negedge clk);
    end else begin
      drive(3'd7, 8'h12, 8'h34);
      chk_out("illegal_op", 8'h00, 1, 0, 1, 1);
      drive(3'd5, 8'h0F, 8'hF0);
      chk_out("after_illegal", 8'hFF, 0, 0, 0, 1);
      @(negedge clk);
      drive(3'd0, 8'h7F, 8'h01);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_out("rst_clear", 8'h00, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
    end

    drive(3'd0, 8'h01, 8'h01);
    chk_out("add_after_rst", 8'h02, 0, 0, 0, 1);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
